// File: rtl/hwag_angle_channel.sv
// Angle-triggered output channel: drives one output between a programmed set
// angle and clear angle of the running generator angle count, with shadowed
// angle registers (transferred at revolution wrap), an on-time safety limit
// and one-cycle event strobes.
module hwag_angle_channel #(
  parameter int unsigned ANGLE_WIDTH = 24,
  parameter int unsigned ANGLE_TOP   = 3839,
  parameter int unsigned TMO_WIDTH   = 16,
  parameter bit          OUT_POL     = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   hwag_start,
  input  logic [ANGLE_WIDTH-1:0] acnt,
  input  logic                   cfg_we,
  input  logic [ANGLE_WIDTH-1:0] cfg_set_angle,
  input  logic [ANGLE_WIDTH-1:0] cfg_clr_angle,
  input  logic [TMO_WIDTH-1:0]   cfg_max_on,
  output logic                   out,
  output logic                   active,
  output logic                   upd_pending,
  output logic                   ev_set,
  output logic                   ev_clr,
  output logic                   ev_tmo
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SYNC,
    ARMED,
    ACTIVE,
    LOCKOUT
  } state_t;

  localparam logic [ANGLE_WIDTH-1:0] TOP  = ANGLE_WIDTH'(ANGLE_TOP);
  localparam logic [ANGLE_WIDTH-1:0] HALF = ANGLE_WIDTH'(ANGLE_TOP / 2);

  state_t                 state, state_nx;
  logic [ANGLE_WIDTH-1:0] prev_acnt, diff;
  logic [ANGLE_WIDTH-1:0] sh_set, sh_clr, act_set, act_clr;
  logic [TMO_WIDTH-1:0]   on_cnt, max_on_m1;
  logic                   step_fwd, step_wrap, set_hit, clr_hit, xfer;
  logic                   ev_set_nx, ev_clr_nx, ev_tmo_nx, on_clear;

  // Target t is crossed by the step prev -> cur (forward or wrapping).
  function automatic logic crossed(input logic [ANGLE_WIDTH-1:0] t,
                                   input logic [ANGLE_WIDTH-1:0] prv,
                                   input logic [ANGLE_WIDTH-1:0] cur,
                                   input logic fwd, input logic wrp);
    crossed = 1'b0;
    if (t <= TOP) begin
      if (fwd)      crossed = (t > prv) && (t <= cur);
      else if (wrp) crossed = (t > prv) || (t <= cur);
    end
  endfunction

  // Step classification, angle hits and shadow-transfer condition.
  always_comb begin
    diff      = prev_acnt - acnt;
    step_fwd  = acnt > prev_acnt;
    step_wrap = (acnt < prev_acnt) && (diff > HALF);
    set_hit   = hwag_start && crossed(act_set, prev_acnt, acnt, step_fwd, step_wrap);
    clr_hit   = hwag_start && crossed(act_clr, prev_acnt, acnt, step_fwd, step_wrap);
    xfer      = step_wrap || (state == IDLE) || (state == WAIT_SYNC);
    max_on_m1 = cfg_max_on - TMO_WIDTH'(1);
  end

  // Next-state and event logic; enable loss and sync loss override everything.
  always_comb begin
    state_nx  = state;
    ev_set_nx = 1'b0;
    ev_clr_nx = 1'b0;
    ev_tmo_nx = 1'b0;
    on_clear  = 1'b0;
    if (!ena) begin
      state_nx = IDLE;
    end else if ((state != IDLE) && !hwag_start) begin
      state_nx = WAIT_SYNC;
    end else begin
      case (state)
        IDLE:      state_nx = WAIT_SYNC;
        WAIT_SYNC: state_nx = ARMED;
        ARMED: begin
          ev_set_nx = set_hit;
          ev_clr_nx = clr_hit;
          // set and clr in one step cancel: channel stays off
          if (set_hit && !clr_hit) begin
            state_nx = ACTIVE;
            on_clear = 1'b1;
          end
        end
        ACTIVE: begin
          if (clr_hit) begin
            ev_clr_nx = 1'b1;
            state_nx  = ARMED;
          end else if ((cfg_max_on != '0) && (on_cnt == max_on_m1)) begin
            ev_tmo_nx = 1'b1;
            state_nx  = LOCKOUT;
          end
        end
        LOCKOUT:   if (step_wrap) state_nx = ARMED;
        default:   state_nx = IDLE;
      endcase
    end
  end

  // State, angle history, shadow/active registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      prev_acnt   <= '0;
      sh_set      <= '0;
      sh_clr      <= '0;
      act_set     <= '0;
      act_clr     <= '0;
      on_cnt      <= '0;
      upd_pending <= 1'b0;
      out         <= ~OUT_POL;
      active      <= 1'b0;
      ev_set      <= 1'b0;
      ev_clr      <= 1'b0;
      ev_tmo      <= 1'b0;
    end else begin
      state     <= state_nx;
      prev_acnt <= acnt;
      if (on_clear)
        on_cnt <= '0;
      else if (state == ACTIVE)
        on_cnt <= on_cnt + TMO_WIDTH'(1);
      // transfer moves the old shadow; a same-cycle write stays pending
      if (xfer) begin
        act_set <= sh_set;
        act_clr <= sh_clr;
      end
      if (cfg_we) begin
        sh_set      <= cfg_set_angle;
        sh_clr      <= cfg_clr_angle;
        upd_pending <= 1'b1;
      end else if (xfer) begin
        upd_pending <= 1'b0;
      end
      out    <= (state_nx == ACTIVE) ? OUT_POL : ~OUT_POL;
      active <= (state_nx == ACTIVE);
      ev_set <= ev_set_nx;
      ev_clr <= ev_clr_nx;
      ev_tmo <= ev_tmo_nx;
    end
  end

endmodule

// File: tb/tb_hwag_angle_channel.sv
// Scoreboard bench for hwag_angle_channel: every driven cycle a behavioural
// model pushes the expected registered outputs; a monitor pops and compares
// one entry after each clock edge.
module tb_hwag_angle_channel;

  localparam int AW  = 24;
  localparam int TW  = 16;
  localparam int TOP = 3839;
  localparam int REV = TOP + 1;
  localparam bit POL = 1'b1;

  logic          clk = 1'b0;
  logic          rst, ena, hwag_start, cfg_we;
  logic [AW-1:0] acnt, cfg_set_angle, cfg_clr_angle;
  logic [TW-1:0] cfg_max_on;
  logic          out, active, upd_pending, ev_set, ev_clr, ev_tmo;

  always #5 clk = ~clk;

  hwag_angle_channel #(
    .ANGLE_WIDTH(AW),
    .ANGLE_TOP  (TOP),
    .TMO_WIDTH  (TW),
    .OUT_POL    (POL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .hwag_start   (hwag_start),
    .acnt         (acnt),
    .cfg_we       (cfg_we),
    .cfg_set_angle(cfg_set_angle),
    .cfg_clr_angle(cfg_clr_angle),
    .cfg_max_on   (cfg_max_on),
    .out          (out),
    .active       (active),
    .upd_pending  (upd_pending),
    .ev_set       (ev_set),
    .ev_clr       (ev_clr),
    .ev_tmo       (ev_tmo)
  );

  // expected {out, active, upd_pending, ev_set, ev_clr, ev_tmo}
  logic [5:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model: channel described as flags, angles as plain ints
  int m_prev, m_sh_set, m_sh_clr, m_act_set, m_act_clr, m_oncycles;
  bit m_pend, m_run, m_synced, m_on, m_locked;

  function automatic int circ(input int v);
    return ((v % REV) + REV) % REV;
  endfunction

  // t lies on the arc swept moving forward from p (exclusive) to c (inclusive)
  function automatic bit on_arc(input int t, input int p, input int c);
    if (t > TOP) return 1'b0;
    return (circ(t - p) >= 1) && (circ(t - p) <= circ(c - p));
  endfunction

  task automatic model_reset();
    m_prev = 0; m_sh_set = 0; m_sh_clr = 0; m_act_set = 0; m_act_clr = 0;
    m_oncycles = 0; m_pend = 0; m_run = 0; m_synced = 0; m_on = 0; m_locked = 0;
  endtask

  task automatic model_step();
    int a;
    bit moved, wrapped, hs, hc, xf, es, ec, et;
    if (rst) begin
      model_reset();
      exp_q.push_back({~POL, 5'b0});
      return;
    end
    a       = int'(acnt);
    wrapped = (a < m_prev) && ((m_prev - a) > TOP / 2);
    moved   = (a > m_prev) || wrapped;
    hs      = hwag_start && moved && on_arc(m_act_set, m_prev, a);
    hc      = hwag_start && moved && on_arc(m_act_clr, m_prev, a);
    xf      = wrapped || !m_synced;
    es = 0; ec = 0; et = 0;
    if (!ena) begin
      m_run = 0; m_synced = 0; m_on = 0; m_locked = 0;
    end else if (!m_run) begin
      m_run = 1;
    end else if (!hwag_start) begin
      m_synced = 0; m_on = 0; m_locked = 0;
    end else if (!m_synced) begin
      m_synced = 1;
    end else if (m_locked) begin
      if (wrapped) m_locked = 0;
    end else if (m_on) begin
      m_oncycles++;
      if (hc) begin
        m_on = 0; ec = 1;
      end else if (cfg_max_on != 0 && m_oncycles == int'(cfg_max_on)) begin
        m_on = 0; m_locked = 1; et = 1;
      end
    end else begin
      es = hs; ec = hc;
      if (hs && !hc) begin
        m_on = 1; m_oncycles = 0;
      end
    end
    if (xf) begin
      m_act_set = m_sh_set; m_act_clr = m_sh_clr; m_pend = 0;
    end
    if (cfg_we) begin
      m_sh_set = int'(cfg_set_angle); m_sh_clr = int'(cfg_clr_angle); m_pend = 1;
    end
    m_prev = a;
    exp_q.push_back({m_on ? POL : ~POL, m_on, m_pend, es, ec, et});
  endtask

  // monitor: one comparison per clock edge, sampled 2 time units after it
  initial begin
    logic [5:0] e, got;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {out, active, upd_pending, ev_set, ev_clr, ev_tmo};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL cyc%0d out/active/upd/set/clr/tmo got=%b exp=%b (acnt=%0d)",
                   cyc, got, e, acnt);
        end
      end
    end
  end

  // drive one cycle: inputs already set, model predicts the post-edge outputs
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic goto(input int a, input int hold);
    acnt = AW'(a);
    ticks(hold);
  endtask

  task automatic sweep(input int from, input int to, input int stride, input int hold);
    for (int a = from; a <= to; a += stride) goto(a, hold);
  endtask

  task automatic write_cfg(input int s, input int c);
    cfg_we = 1'b1;
    cfg_set_angle = AW'(s);
    cfg_clr_angle = AW'(c);
    tick();
    cfg_we = 1'b0;
  endtask

  // finish a revolution and wrap to angle w
  task automatic wrap_to(input int w);
    goto(TOP - 1, 1);
    goto(TOP, 1);
    goto(w, 2);
  endtask

  initial begin
    int r, a;
    model_reset();
    rst = 1'b1; ena = 1'b0; hwag_start = 1'b0; cfg_we = 1'b0;
    acnt = '0; cfg_set_angle = '0; cfg_clr_angle = '0; cfg_max_on = '0;
    ticks(3);
    rst = 1'b0;

    // basic window, full sweep
    write_cfg(100, 200);
    ena = 1'b1; hwag_start = 1'b1;
    ticks(3);
    sweep(0, TOP, 1, 4);
    goto(0, 4);

    // window spanning the wrap (shadowed, so effective after one wrap)
    write_cfg(3800, 50);
    sweep(5, 3835, 5, 1);
    wrap_to(0);
    sweep(5, 3835, 5, 1);
    sweep(3836, TOP, 1, 1);
    sweep(0, 60, 1, 2);

    // jump across the set angle
    write_cfg(100, 200);
    sweep(65, 3835, 10, 1);
    wrap_to(0);
    goto(95, 2);
    goto(105, 3);
    goto(250, 2);

    // on-time limit, lockout, no refire until wrap
    cfg_max_on = 16'd20;
    wrap_to(0);
    goto(90, 1);
    goto(150, 30);
    goto(90, 2);
    goto(110, 3);
    wrap_to(0);
    goto(120, 10);
    goto(200, 3);
    cfg_max_on = 16'd1;
    wrap_to(0);
    goto(120, 4);
    cfg_max_on = '0;

    // shadow write mid-revolution
    goto(1000, 1);
    write_cfg(300, 400);
    goto(250, 2);
    goto(350, 3);
    wrap_to(0);
    sweep(10, 500, 10, 2);

    // resync step, sync loss while active, set == clr
    goto(490, 3);
    wrap_to(0);
    goto(310, 3);
    hwag_start = 1'b0;
    ticks(2);
    hwag_start = 1'b1;
    ticks(2);
    goto(420, 2);
    write_cfg(100, 100);
    wrap_to(0);
    goto(150, 3);

    // reset while active
    write_cfg(100, 200);
    wrap_to(0);
    goto(150, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(4);
    goto(180, 2);

    // randomised phase
    a = 180;
    for (int i = 0; i < 20000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      a = (a + int'($urandom_range(0, 40))) % REV;
      else if (r < 80) a = int'($urandom_range(0, TOP));
      acnt = AW'(a);
      if ($urandom_range(0, 99) < 2)   hwag_start = ~hwag_start;
      if ($urandom_range(0, 199) < 1)  ena = ~ena;
      if ($urandom_range(0, 499) < 1)  rst = 1'b1;
      if ($urandom_range(0, 199) < 1)  cfg_max_on = TW'($urandom_range(0, 60));
      if ($urandom_range(0, 99) < 3) begin
        cfg_we = 1'b1;
        cfg_set_angle = AW'($urandom_range(0, TOP));
        r = int'($urandom_range(0, 9));
        if (r == 0)      cfg_clr_angle = cfg_set_angle;
        else if (r == 1) cfg_clr_angle = AW'(TOP + 1 + int'($urandom_range(0, 100)));
        else             cfg_clr_angle = AW'(circ(int'(cfg_set_angle) + int'($urandom_range(1, 600))));
      end
      tick();
      rst = 1'b0;
      cfg_we = 1'b0;
    end

    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hwag_angle_channel.md
Name: hwag_angle_channel

Overview:
Angle-triggered output channel downstream of the hardware angle generator. It consumes the running angle count (0..3839 per revolution) and the sync-valid flag, and drives one output (ignition coil or injector) between a programmed set angle and clear angle. It includes shadowed angle registers updated at revolution wrap, a maximum on-time safety timeout and event strobes for the interrupt flag register. One instance is used per output channel.

Parameters:
ANGLE_WIDTH, 24, width of angle count and angle registers
ANGLE_TOP, 3839, last angle value before the count wraps to 0
TMO_WIDTH, 16, width of the on-time limit and on-time counter
OUT_POL, 1, active level of out (1 = active high)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
ena  in  1  channel enable (control register bit)
hwag_start  in  1  angle count valid (generator synchronised)
acnt  in  ANGLE_WIDTH  angle count from generator
cfg_we  in  1  write strobe for shadow registers
cfg_set_angle  in  ANGLE_WIDTH  angle at which out asserts
cfg_clr_angle  in  ANGLE_WIDTH  angle at which out deasserts
cfg_max_on  in  TMO_WIDTH  on-time limit in clk cycles, 0 = no limit
out  out  1  channel output
active  out  1  state == ACTIVE
upd_pending  out  1  shadow written, not yet transferred
ev_set  out  1  one-cycle strobe, set angle crossed
ev_clr  out  1  one-cycle strobe, clear angle crossed
ev_tmo  out  1  one-cycle strobe, on-time limit hit

Behaviour:
- Reset values: out = ~OUT_POL (inactive); active, upd_pending, ev_* = 0; state IDLE; prev_acnt, shadow and active angles, on_cnt = 0.
- prev_acnt captures acnt on every cycle.
- Step classification, with d = prev_acnt - acnt:
  - acnt == prev: none.
  - acnt > prev: forward.
  - acnt < prev and d > ANGLE_TOP/2: wrap.
  - acnt < prev otherwise: resync. Resync produces no hits and no transfer.
- Hit on target t:
  - forward step: prev < t <= acnt.
  - wrap step: t > prev or t <= acnt.
  - t > ANGLE_TOP never hits.
- Hits use the active angle registers only, and are evaluated only when hwag_start = 1.
- Shadow: cfg_we loads the shadow registers and sets upd_pending. Transfer shadow→active occurs:
  - in the cycle a wrap is detected, or
  - in any cycle in IDLE or WAIT_SYNC.
  - The transfer clears upd_pending. New values take effect the next cycle. cfg_we in the same cycle as a transfer wins: upd_pending stays 1 and the new data transfers at the next wrap.
- States and transitions:
  - IDLE: out inactive. ena=1 → WAIT_SYNC.
  - WAIT_SYNC: hwag_start=1 → ARMED.
  - ARMED: set hit → ACTIVE, on_cnt = 0.
  - ACTIVE: out active. on_cnt += 1 per cycle.
    - clr hit → ARMED.
    - cfg_max_on != 0 and on_cnt == cfg_max_on-1 → LOCKOUT, ev_tmo.
  - LOCKOUT: out inactive. wrap → ARMED.
  - From any state: ena=0 → IDLE. From any state except IDLE: hwag_start=0 → WAIT_SYNC. Both force out inactive on the next edge.
- Simultaneous set and clr hit in one step:
  - in ARMED: stay ARMED, pulse ev_set and ev_clr, out never asserts (set == clr angle gives a disabled channel);
  - in ACTIVE: clr is honoured (→ ARMED), set is ignored.
- Timeout and clr hit in the same cycle: clr wins (→ ARMED), no ev_tmo.
- Latency: out, active and ev_* are registered and change 1 clk after the acnt value that causes the hit. The timeout drives out inactive exactly cfg_max_on cycles after out went active.
- Rst mid-operation returns all outputs to reset values on the next edge.

Test Plan:
- Setup: ena=1, hwag_start=1, set=100, clr=200, max_on=0. Sweep acnt 0..3839 by +1 every 4 clks → out active from the cycle after acnt=100 to the cycle after acnt=200; ev_set and ev_clr each pulse once.
- Wrap window: set=3800, clr=50, acnt stepping 3838→3839→0 → out active across the wrap, clears after acnt=50. Jump acnt 95→105 with set=100 → hit.
- Timeout: set=100, clr=200, max_on=20, acnt held at 150 after crossing 100 → out active 20 cycles, ev_tmo, LOCKOUT. Later crossing of 100 in the same revolution does not re-fire; after wrap the channel re-arms.
- Shadow: write set=300 at acnt=1000 → upd_pending=1, and the next crossing of 300 in the same revolution does not fire (old set=100 stays active). After wrap, upd_pending=0 and firing occurs at 300.
- Resync/sync loss: acnt 500→490 → no hits, no transfer. hwag_start drops while ACTIVE → out inactive next cycle, state WAIT_SYNC. set==clr=100 → ev_set and ev_clr pulse together, out stays inactive.
- rst asserted while ACTIVE → next edge out=~OUT_POL, all strobes 0, state IDLE.
